// File: rtl/oled_page_arbiter.sv
// rtl/oled_page_arbiter.sv - round-robin page writer and refresh sequencer for the 4-page OLED text display
// Requesters write a shadow page buffer; refreshes snapshot it to page0..3 and run the EN/FIN handshake.
module oled_page_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int HOLDOFF_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   req_page,
  input  logic [128*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [127:0]           page0,
  output logic [127:0]           page1,
  output logic [127:0]           page2,
  output logic [127:0]           page3,
  output logic                   oled_en,
  input  logic                   oled_fin,
  output logic [3:0]             dirty,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = (HOLDOFF_CYCLES > 2) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNAP,
    S_ASSERT,
    S_RELEASE,
    S_HOLDOFF
  } state_t;

  state_t            state_q;
  logic [IW-1:0]     start_q;
  logic [3:0]        dirty_q;
  logic              oled_en_q;
  logic              terr_q;
  logic [HW-1:0]     hcnt_q;
  logic [TW-1:0]     tcnt_q;
  logic [127:0]      shadow_q [4];
  logic [127:0]      snap_q   [4];

  logic [NUM_REQ-1:0] hi_req;
  logic               gnt_vld;
  logic [IW-1:0]      gnt_sel;
  logic [1:0]         gnt_page;
  logic [127:0]       gnt_data;
  logic [3:0]         gnt_mask;
  logic [IW-1:0]      start_d;

  // Requests at or above the start index win; otherwise wrap to the lowest requester.
  always_comb begin
    hi_req   = req & ~((NUM_REQ'(1) << start_q) - NUM_REQ'(1));
    gnt_vld  = |req;
    gnt_sel  = '0;
    gnt_page = '0;
    gnt_data = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        gnt_sel  = IW'(k);
        gnt_page = req_page[2*k +: 2];
        gnt_data = req_data[128*k +: 128];
      end
    end
    if (hi_req != '0) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (hi_req[k]) begin
          gnt_sel  = IW'(k);
          gnt_page = req_page[2*k +: 2];
          gnt_data = req_data[128*k +: 128];
        end
      end
    end
    gnt      = gnt_vld ? (NUM_REQ'(1) << gnt_sel) : '0;
    gnt_mask = gnt_vld ? (4'b0001 << gnt_page) : 4'b0000;
    start_d  = (gnt_sel == IW'(NUM_REQ - 1)) ? '0 : gnt_sel + IW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      start_q   <= '0;
      dirty_q   <= '0;
      oled_en_q <= 1'b0;
      terr_q    <= 1'b0;
      hcnt_q    <= '0;
      tcnt_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= '0;
        snap_q[i]   <= '0;
      end
    end else begin
      if (gnt_vld) begin
        shadow_q[gnt_page] <= gnt_data;
        start_q            <= start_d;
      end
      // A grant landing on the snapshot edge keeps its dirty bit for the next refresh.
      dirty_q <= ((state_q == S_SNAP) ? 4'b0000 : dirty_q) | gnt_mask;
      case (state_q)
        S_IDLE: begin
          if ((dirty_q | gnt_mask) != 4'b0000) state_q <= S_SNAP;
        end
        S_SNAP: begin
          for (int i = 0; i < 4; i++) snap_q[i] <= shadow_q[i];
          oled_en_q <= 1'b1;
          tcnt_q    <= '0;
          state_q   <= S_ASSERT;
        end
        S_ASSERT: begin
          if (oled_fin) begin
            oled_en_q <= 1'b0;
            state_q   <= S_RELEASE;
          end else if (32'(tcnt_q) + 32'd1 >= 32'(TIMEOUT_CYCLES)) begin
            terr_q    <= 1'b1;
            oled_en_q <= 1'b0;
            hcnt_q    <= '0;
            state_q   <= S_HOLDOFF;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        S_RELEASE: begin
          if (!oled_fin) begin
            hcnt_q  <= '0;
            state_q <= S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          if (32'(hcnt_q) + 32'd2 >= 32'(HOLDOFF_CYCLES)) state_q <= S_IDLE;
          else hcnt_q <= hcnt_q + HW'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign page0       = snap_q[0];
  assign page1       = snap_q[1];
  assign page2       = snap_q[2];
  assign page3       = snap_q[3];
  assign oled_en     = oled_en_q;
  assign dirty       = dirty_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = terr_q;

endmodule
